mux_n_scan: RTL and testbench
=============================

# mux_n_scan

Parametrised, registered N-channel multiplexer with a manual-select mode and an automatic round-robin scan mode. Each channel is held for a programmable number of cycles in scan mode. It replaces fixed 8-way combinational selectors where the datapath needs a registered output, the current channel index, and a periodic sweep over all sources, for example display or sensor multiplexing.

## Interface
Parameters:
- INPUT_BITS, 2, width of each channel
- CHANNELS, 8, number of channels; ≥1; need not be a power of two
- DWELL, 4, cycles each channel is held in scan mode; ≥1
- SEL_BITS, derived localparam = max(1, $clog2(CHANNELS))

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, synchronous and active-low
- E  in  CHANNELS*INPUT_BITS  flattened inputs; channel k at bits [k*INPUT_BITS +: INPUT_BITS]
- S  in  SEL_BITS  manual channel select
- MODE  in  1  0 = manual, 1 = scan
- EN  in  1  clock enable for all state
- F  out  INPUT_BITS  registered selected data
- CH  out  SEL_BITS  channel currently driving F
- VALID  out  1  high when F was loaded on the previous edge
- WRAP  out  1  one-cycle pulse when scan wraps CHANNELS-1 → 0

## Operation
- States: MANUAL and SCAN. The state register follows MODE at each enabled edge. Internal dwell counter `cnt` has range 0..DWELL-1.
- Each enabled edge computes `ch_next` and loads both `CH <= ch_next` and `F <= E[ch_next]`. F and CH are therefore always consistent.
- **MANUAL** (MODE=0):
  - `ch_next = S` if S < CHANNELS; otherwise `ch_next = CH`, so an out-of-range select is ignored.
  - `cnt <= 0`, WRAP=0.
- **SCAN** (MODE=1):
  - If `cnt < DWELL-1`: `cnt <= cnt+1`, `ch_next = CH`.
  - If `cnt == DWELL-1`: `cnt <= 0`, and `ch_next = CH+1`, or 0 when CH == CHANNELS-1. WRAP is 1 on that wrap edge only.
  - F re-samples E[CH] on every enabled cycle, including dwell cycles, so live input changes propagate.
- **MANUAL→SCAN** (first enabled edge with MODE=1 while in MANUAL):
  - `cnt <= 0`, `ch_next = CH`.
  - Scan starts at the current channel and holds it for a full DWELL window, counting this edge as the first.
- **SCAN→MANUAL**: takes effect on the same edge. `ch_next` follows S, `cnt <= 0`.
- **EN=0**: F, CH, `cnt` and state all hold. VALID and WRAP are registered to 0.
- **VALID**: registered copy of EN, high in the cycle after each enabled edge.
- **Reset**: rst_n low at an edge forces F=0, CH=0, `cnt`=0, state=MANUAL, VALID=0, WRAP=0. Reset dominates EN and MODE and may abort a scan at any point.
- **DWELL=1**: the channel advances on every enabled scan edge.
- **CHANNELS=1**: CH stays 0 and WRAP pulses on every DWELL-th enabled scan edge.

## Timing
- Latency from E/S to F/CH is 1 cycle. There is no combinational path from any input to any output.
- Scan period is CHANNELS*DWELL enabled cycles. WRAP spacing is exactly CHANNELS*DWELL enabled cycles in steady scan.
- VALID and WRAP are 1-cycle registered pulses aligned with the F value they describe.
- First edge after rst_n deasserts behaves as a normal enabled or disabled edge; there is no dead cycle.

## Test plan
Configuration for all scenarios: INPUT_BITS=4, CHANNELS=5, DWELL=2, E = {4'h5, 4'h4, 4'h3, 4'h2, 4'h1} (ch0 = 1 … ch4 = 5).
- **Reset:** drive rst_n=0 for 2 edges with EN=1, MODE=1 → F=0, CH=0, VALID=0, WRAP=0. Release → next edge gives F=1, CH=0, VALID=1.
- **Manual select:** MODE=0, EN=1, S=3 → one edge later F=4, CH=3. Then S=6 (out of range) → F=4, CH=3 hold (F still re-samples E[3]).
- **Scan sweep:** MODE=1 from CH=0 → CH sequence 0,0,1,1,2,2,3,3,4,4,0. WRAP=1 only on the edge where CH becomes 0. Next WRAP arrives exactly 10 cycles later.
- **Enable freeze:** mid-scan with CH=2 and `cnt`=1, drop EN for 3 cycles → F, CH hold and VALID=0. Restore EN → CH=3 on the first edge.
- **Mode switching:** scanning at CH=4, set MODE=0 with S=1 → CH=1 next edge. Set MODE=1 → CH holds at 1 for 2 edges, then 2.
- **Live data:** hold CH=2 in manual, change E[2] from 3 to 9 → F=9 one edge later, VALID=1.

Source files
------------

// File: rtl/mux_n_scan.sv
// mux_n_scan: registered N-channel mux with manual select and round-robin scan mode
module mux_n_scan #(
  parameter int INPUT_BITS = 2,
  parameter int CHANNELS = 8,
  parameter int DWELL = 4,
  localparam int SEL_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNT_BITS = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*INPUT_BITS-1:0] E,
  input  logic [SEL_BITS-1:0]            S,
  input  logic                           MODE,
  input  logic                           EN,
  output logic [INPUT_BITS-1:0]          F,
  output logic [SEL_BITS-1:0]            CH,
  output logic                           VALID,
  output logic                           WRAP
);
  typedef enum logic {MANUAL, SCAN} state_t;
  state_t state, state_nx;
  logic [CNT_BITS-1:0] cnt, cnt_nx;
  logic [SEL_BITS-1:0] ch_nx;
  logic wrap_nx;
  logic last_ch, dwell_done;
  logic [INPUT_BITS-1:0] e_arr [CHANNELS];
  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign e_arr[i] = E[i*INPUT_BITS +: INPUT_BITS];
  end
  assign last_ch = 32'(CH) == CHANNELS - 1;
  assign dwell_done = 32'(cnt) == DWELL - 1;
  // next channel, dwell count and wrap pulse; scan entry restarts the dwell window at the current channel
  always_comb begin
    state_nx = state;
    ch_nx = CH;
    cnt_nx = cnt;
    wrap_nx = 1'b0;
    if (EN) begin
      state_nx = MODE ? SCAN : MANUAL;
      if (!MODE) begin
        ch_nx = (32'(S) < CHANNELS) ? S : CH;
        cnt_nx = '0;
      end else if (state == MANUAL) begin
        cnt_nx = '0;
      end else if (dwell_done) begin
        cnt_nx = '0;
        ch_nx = last_ch ? '0 : CH + 1'b1;
        wrap_nx = last_ch;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end
  // state, channel and data registers; F is loaded from the same ch_nx as CH so they always agree
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MANUAL;
      cnt <= '0;
      CH <= '0;
      F <= '0;
      VALID <= 1'b0;
      WRAP <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      CH <= ch_nx;
      VALID <= EN;
      WRAP <= wrap_nx;
      if (EN) F <= e_arr[ch_nx];
    end
  end
endmodule

// File: tb/tb_mux_n_scan.sv
// tb_mux_n_scan: directed and randomized checks of mux_n_scan against an arithmetic scan model
module tb_mux_n_scan;
  localparam int IB = 4, NC = 5, DW = 2, SB = 3;
  logic clk = 0, rst_n = 0, MODE = 0, EN = 0;
  logic [NC*IB-1:0] E = 20'h54321;
  logic [SB-1:0] S = 0;
  logic [IB-1:0] F;
  logic [SB-1:0] CH;
  logic VALID, WRAP;
  int cmp = 0, err = 0;
  int m_ch = 0, m_k = 0, m_start = 0;
  bit m_scan = 0, m_valid = 0, m_wrap = 0;
  logic [IB-1:0] m_f = 0;

  mux_n_scan #(.INPUT_BITS(IB), .CHANNELS(NC), .DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .E(E), .S(S), .MODE(MODE), .EN(EN),
    .F(F), .CH(CH), .VALID(VALID), .WRAP(WRAP)
  );

  always #5 clk = ~clk;

  // scan position k counts enabled scan edges since entry; channel = start + k/DWELL mod CHANNELS
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_ch = 0; m_f = 0; m_valid = 0; m_wrap = 0; m_scan = 0;
    end else if (!EN) begin
      m_valid = 0; m_wrap = 0;
    end else begin
      m_valid = 1; m_wrap = 0;
      if (!MODE) begin
        m_scan = 0;
        if (S < NC) m_ch = S;
      end else if (!m_scan) begin
        m_scan = 1; m_start = m_ch; m_k = 0;
      end else begin
        m_k++;
        m_ch = (m_start + m_k / DW) % NC;
        m_wrap = (m_k % DW == 0) && (m_ch == 0);
      end
      m_f = E[m_ch*IB +: IB];
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; EN = 1; MODE = 1;
    tick(); tick();
    cmp++; if (F !== 4'h0) begin err++; $display("FAIL reset_f got %h want 0", F); end
    cmp++; if (CH !== 3'd0) begin err++; $display("FAIL reset_ch got %0d want 0", CH); end
    cmp++; if (VALID !== 1'b0) begin err++; $display("FAIL reset_valid got %b want 0", VALID); end
    cmp++; if (WRAP !== 1'b0) begin err++; $display("FAIL reset_wrap got %b want 0", WRAP); end
    rst_n = 1;
    tick();
    cmp++; if (F !== 4'h1 || CH !== 3'd0 || VALID !== 1'b1) begin
      err++; $display("FAIL reset_release got F=%h CH=%0d V=%b want F=1 CH=0 V=1", F, CH, VALID);
    end
  endtask

  task automatic test_manual();
    MODE = 0; S = 3;
    tick();
    cmp++; if (F !== 4'h4 || CH !== 3'd3) begin err++; $display("FAIL manual_sel got F=%h CH=%0d want F=4 CH=3", F, CH); end
    S = 6;
    tick();
    cmp++; if (F !== 4'h4 || CH !== 3'd3 || VALID !== 1'b1) begin
      err++; $display("FAIL manual_oor got F=%h CH=%0d V=%b want F=4 CH=3 V=1", F, CH, VALID);
    end
  endtask

  task automatic test_scan_sweep();
    int exp_ch[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0};
    int n;
    MODE = 0; S = 0;
    tick();
    MODE = 1;
    for (int i = 0; i < 11; i++) begin
      tick();
      cmp++; if (CH !== 3'(exp_ch[i]) || F !== 4'(exp_ch[i] + 1)) begin
        err++; $display("FAIL sweep_ch[%0d] got CH=%0d F=%h want CH=%0d F=%h", i, CH, F, exp_ch[i], exp_ch[i] + 1);
      end
      cmp++; if (WRAP !== (i == 10)) begin err++; $display("FAIL sweep_wrap[%0d] got %b want %b", i, WRAP, i == 10); end
    end
    n = 0;
    do begin tick(); n++; end while (!WRAP && n < 30);
    cmp++; if (n != NC * DW) begin err++; $display("FAIL wrap_period got %0d want %0d", n, NC * DW); end
  endtask

  task automatic test_enable_freeze();
    MODE = 0; S = 2;
    tick();
    MODE = 1;
    tick(); tick();
    EN = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp++; if (CH !== 3'd2 || F !== 4'h3 || VALID !== 1'b0 || WRAP !== 1'b0) begin
        err++; $display("FAIL freeze[%0d] got CH=%0d F=%h V=%b W=%b want CH=2 F=3 V=0 W=0", i, CH, F, VALID, WRAP);
      end
    end
    EN = 1;
    tick();
    cmp++; if (CH !== 3'd3 || F !== 4'h4 || VALID !== 1'b1) begin
      err++; $display("FAIL freeze_resume got CH=%0d F=%h V=%b want CH=3 F=4 V=1", CH, F, VALID);
    end
  endtask

  task automatic test_mode_switch();
    int exp_ch[3] = '{1, 1, 2};
    MODE = 0; S = 4;
    tick();
    MODE = 1;
    tick();
    MODE = 0; S = 1;
    tick();
    cmp++; if (CH !== 3'd1 || F !== 4'h2) begin err++; $display("FAIL to_manual got CH=%0d F=%h want CH=1 F=2", CH, F); end
    MODE = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp++; if (CH !== 3'(exp_ch[i])) begin err++; $display("FAIL to_scan[%0d] got CH=%0d want %0d", i, CH, exp_ch[i]); end
    end
  endtask

  task automatic test_live_data();
    MODE = 0; S = 2;
    tick();
    E[11:8] = 4'h9;
    tick();
    cmp++; if (F !== 4'h9 || CH !== 3'd2 || VALID !== 1'b1) begin
      err++; $display("FAIL live_data got F=%h CH=%0d V=%b want F=9 CH=2 V=1", F, CH, VALID);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = $urandom_range(0, 49) != 0;
      EN = $urandom_range(0, 4) != 0;
      if ($urandom_range(0, 9) == 0) MODE = ~MODE;
      S = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) E = 20'($urandom);
      tick();
      cmp++; if (F !== m_f) begin err++; $display("FAIL rand_f[%0d] got %h want %h", i, F, m_f); end
      cmp++; if (CH !== 3'(m_ch)) begin err++; $display("FAIL rand_ch[%0d] got %0d want %0d", i, CH, m_ch); end
      cmp++; if (VALID !== m_valid) begin err++; $display("FAIL rand_valid[%0d] got %b want %b", i, VALID, m_valid); end
      cmp++; if (WRAP !== m_wrap) begin err++; $display("FAIL rand_wrap[%0d] got %b want %b", i, WRAP, m_wrap); end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_sweep();
    test_enable_freeze();
    test_mode_switch();
    test_live_data();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
